// File: rtl/sc_gb_pkg.sv
// Shared types and constants for the stochastic 3x3 Gaussian blur kernel:
// FSM states, window index names, select mapping and LFSR tap masks.
package sc_gb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Row-major 3x3 window positions; index 4 is the centre pixel.
  localparam logic [3:0] IDX_NW     = 4'd0;
  localparam logic [3:0] IDX_N      = 4'd1;
  localparam logic [3:0] IDX_NE     = 4'd2;
  localparam logic [3:0] IDX_W      = 4'd3;
  localparam logic [3:0] IDX_CENTRE = 4'd4;
  localparam logic [3:0] IDX_E      = 4'd5;
  localparam logic [3:0] IDX_SW     = 4'd6;
  localparam logic [3:0] IDX_S      = 4'd7;
  localparam logic [3:0] IDX_SE     = 4'd8;

  // Fibonacci tap masks, bit k set for polynomial term x^(k+1).
  localparam logic [7:0]  TAPS_W8  = 8'hB8;    // x^8+x^6+x^5+x^4+1
  localparam logic [11:0] TAPS_W12 = 12'h829;  // x^12+x^6+x^4+x+1
  localparam logic [15:0] TAPS_W16 = 16'hD008; // x^16+x^15+x^13+x^4+1

  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      12:      lfsr_taps = {4'h0, TAPS_W12};
      16:      lfsr_taps = TAPS_W16;
      default: lfsr_taps = {8'h00, TAPS_W8};
    endcase
  endfunction

  // 16-way select realising weights 4 (centre), 2 (edges), 1 (corners).
  function automatic logic [3:0] sel_to_idx(input logic [3:0] s);
    case (s)
      4'd0, 4'd1, 4'd2, 4'd3: sel_to_idx = IDX_CENTRE;
      4'd4, 4'd5:             sel_to_idx = IDX_N;
      4'd6, 4'd7:             sel_to_idx = IDX_W;
      4'd8, 4'd9:             sel_to_idx = IDX_E;
      4'd10, 4'd11:           sel_to_idx = IDX_S;
      4'd12:                  sel_to_idx = IDX_NW;
      4'd13:                  sel_to_idx = IDX_NE;
      4'd14:                  sel_to_idx = IDX_SW;
      default:                sel_to_idx = IDX_SE;
    endcase
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR used as the select source; a zero seed loads 1 so the
// all-zero lock-up state can never be entered.
module sc_lfsr #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   TAPS = W'(8'hB8)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == '0) ? W'(1) : seed;
    end else if (en) begin
      q_d = {q_q[W-2:0], ^(q_q & TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= W'(1);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sc_gb_kernel.sv
// Stochastic-computing 3x3 Gaussian blur: per-lane weighted MUX over a bit
// window, counted over 2^LEN_LOG2 beats. Optional SC_GB_STREAM_OUT_EN adds
// the registered selected-bit stream outputs z_bits / z_bits_valid.
module sc_gb_kernel
  import sc_gb_pkg::*;
#(
  parameter  int NCH      = 2,
  parameter  int LEN_LOG2 = 8,
  parameter  int LFSR_W   = 8,
  localparam int CW       = LEN_LOG2 + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LFSR_W-1:0]   seed,
  input  logic                in_valid,
  input  logic [NCH*9-1:0]    x_bits,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NCH*CW-1:0]   z_count
`ifdef SC_GB_STREAM_OUT_EN
  ,
  output logic [NCH-1:0]      z_bits,
  output logic                z_bits_valid
`endif
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  state_e              state_q;
  logic [LEN_LOG2-1:0] beat_q;
  logic [CW-1:0]       cnt_q [NCH];
  logic [CW-1:0]       cnt_d [NCH];
  logic                busy_q;
  logic                out_valid_q;

  logic [LFSR_W-1:0]   lfsr_q;
  logic                lfsr_unused;
  logic [3:0]          sel_idx;
  logic [NCH-1:0]      sel_bits;
  logic                accept_start;
  logic                beat;
  logic                last_beat;

  assign accept_start = (state_q == IDLE) && start;
  assign beat         = (state_q == RUN) && in_valid;
  assign last_beat    = beat && (beat_q == '1);

  sc_lfsr #(
    .W    (LFSR_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_start),
    .seed  (seed),
    .en    (beat),
    .q     (lfsr_q)
  );

  // Only the low nibble drives the select; upper bits just carry the sequence.
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:4];
  assign sel_idx     = sel_to_idx(lfsr_q[3:0]);

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      sel_bits[n] = x_bits[n*9 + int'(sel_idx)];
      cnt_d[n]    = cnt_q[n] + CW'(sel_bits[n]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      for (int n = 0; n < NCH; n++) cnt_q[n] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            beat_q  <= '0;
            for (int n = 0; n < NCH; n++) cnt_q[n] <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            beat_q <= beat_q + 1'b1;
            for (int n = 0; n < NCH; n++) cnt_q[n] <= cnt_d[n];
            if (last_beat) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;

  always_comb begin
    for (int n = 0; n < NCH; n++) z_count[n*CW +: CW] = cnt_q[n];
  end

`ifdef SC_GB_STREAM_OUT_EN
  logic [NCH-1:0] z_bits_q;
  logic           z_bits_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_bits_q       <= '0;
      z_bits_valid_q <= 1'b0;
    end else begin
      z_bits_valid_q <= beat;
      if (beat) z_bits_q <= sel_bits;
    end
  end

  assign z_bits       = z_bits_q;
  assign z_bits_valid = z_bits_valid_q;
`endif

endmodule
